// File: rtl/dram_access_unit.sv
// Memory-stage data-RAM access unit: word RAM without byte enables, sub-word stores via read-modify-write.
// Latency: load 2, sub-word store 2, word store 1, misaligned 1 cycle to ack; stall = req & ~ack holds the pipeline.
module dram_access_unit #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            ex_type,
    input  logic                  uns,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           rdata,
    output logic                  ack,
    output logic                  err,
    output logic                  stall
);

    typedef enum logic [1:0] {IDLE, LD_CAP, ST_MERGE, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;
    logic [31:0] w_load_ext;
    logic [31:0] w_merge;
    logic        w_unused;

    // ex_type 11 falls into the byte path because only bit0 is tested
    assign w_is_byte    = ex_type[0];
    assign w_is_half    = (ex_type == 2'b10);
    assign w_is_word    = (ex_type == 2'b00);
    assign w_misaligned = (w_is_half & addr[0]) | (w_is_word & (addr[1:0] != 2'b00));

    assign mem_addr = addr[ADDR_WIDTH+1:2];
    assign w_unused = &{1'b0, addr[31:ADDR_WIDTH+2]};

    assign w_byte_sh = mem_rdata >> {addr[1:0], 3'b000};
    assign w_half_sh = mem_rdata >> {addr[1], 4'b0000};

    always_comb begin
        w_load_ext = mem_rdata;
        if (w_is_byte) begin
            w_load_ext = {{24{~uns & w_byte_sh[7]}}, w_byte_sh[7:0]};
        end else if (w_is_half) begin
            w_load_ext = {{16{~uns & w_half_sh[15]}}, w_half_sh[15:0]};
        end
    end

    always_comb begin
        w_merge = mem_rdata;
        if (w_is_byte) begin
            w_merge[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
        end else if (w_is_half) begin
            w_merge[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_we    = 1'b0;
        mem_wdata = wdata;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_misaligned) begin
                        w_next = RESP;
                    end else if (!we) begin
                        w_next = LD_CAP;
                    end else if (w_is_word) begin
                        mem_we = 1'b1;
                        w_next = RESP;
                    end else begin
                        w_next = ST_MERGE;
                    end
                end
            end
            LD_CAP:   w_next = RESP;
            ST_MERGE: begin
                mem_we    = 1'b1;
                mem_wdata = w_merge;
                w_next    = RESP;
            end
            RESP:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
        // A write must never escape while reset is held, even mid read-modify-write
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req) begin
                r_err   <= w_misaligned;
                r_rdata <= 32'd0;
            end else if (r_state == LD_CAP) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    assign ack   = (r_state == RESP);
    assign rdata = r_rdata;
    assign err   = r_err;
    assign stall = req & ~ack;

endmodule

// File: tb/tb_dram_access_unit.sv
// Bench for dram_access_unit: table of accesses against a behavioural synchronous RAM,
// expected results queued at issue and compared on ack, plus a reset-during-merge sequence.
module tb_dram_access_unit;

    localparam int AW = 14;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [1:0]    ex_type;
    logic          uns;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   rdata;
    logic          ack;
    logic          err;
    logic          stall;

    logic [31:0]   ram [0:(1<<AW)-1];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_dat;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  et;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wecyc;
        logic [31:0] exp_wword;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wecyc;
        logic [31:0] wword;
    } exp_t;

    vec_t vq[$];
    exp_t sb_q[$];

    dram_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .ex_type   (ex_type),
        .uns       (uns),
        .addr      (addr),
        .wdata     (wdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .ack       (ack),
        .err       (err),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_dat;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        @(posedge clk); #1;
        pre_en   = 1'b1;
        pre_addr = idx[AW-1:0];
        pre_dat  = d;
        @(posedge clk); #1;
        pre_en   = 1'b0;
    endtask

    task automatic add(input logic w, input logic [1:0] et, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input int wc, input logic [31:0] ww);
        vec_t v;
        v.we = w; v.et = et; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_wecyc = wc; v.exp_wword = ww;
        vq.push_back(v);
    endtask

    task automatic do_op(input vec_t v, input int idx);
        exp_t        e;
        exp_t        got_e;
        int          lat;
        int          wecyc;
        int          stalls;
        logic [31:0] wword;
        @(posedge clk); #1;
        we = v.we; ex_type = v.et; uns = v.uns; addr = v.addr; wdata = v.wdata; req = 1'b1;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        e.wecyc = v.exp_wecyc; e.wword = v.exp_wword;
        sb_q.push_back(e);
        lat = -1; wecyc = -1; stalls = 0; wword = 32'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ack) begin
                lat = c;
                break;
            end
            if (stall) stalls++;
            if (mem_we && wecyc < 0) begin
                wecyc = c;
                wword = mem_wdata;
            end
        end
        got_e = sb_q.pop_front();
        check($sformatf("op%0d ack_latency", idx), lat, got_e.lat);
        check($sformatf("op%0d rdata", idx), rdata, got_e.rdata);
        check($sformatf("op%0d err", idx), {31'd0, err}, {31'd0, got_e.err});
        check($sformatf("op%0d stall_cycles", idx), stalls, got_e.lat);
        check($sformatf("op%0d write_cycle", idx), wecyc, got_e.wecyc);
        if (got_e.wecyc >= 0) begin
            check($sformatf("op%0d write_word", idx), wword, got_e.wword);
        end
        req = 1'b0;
    endtask

    initial begin
        vec_t rv;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; ex_type = 2'b00; uns = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        pre_en = 1'b0; pre_addr = '0; pre_dat = 32'd0;

        preload(4,  32'h0000_0000);
        preload(8,  32'h1122_3344);
        preload(12, 32'hCAFE_F00D);
        preload(16, 32'hFFFF_FFFF);
        preload(20, 32'h80FF_7F01);
        preload(24, 32'h0102_0304);

        req = 1'b1;
        @(negedge clk);
        check("reset ack", {31'd0, ack}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        //   we    et     uns   addr          wdata          rdata          err  lat wc  wword
        add(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1, 0, 32'hDEAD_BEEF);
        add(1'b0, 2'b00, 1'b0, 32'h10, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 2, -1, 32'h0);
        add(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_FFAB, 32'h0000_0000, 1'b0, 2, 1, 32'h11AB_3344);
        add(1'b0, 2'b00, 1'b0, 32'h20, 32'h0000_0000, 32'h11AB_3344, 1'b0, 2, -1, 32'h0);
        add(1'b0, 2'b01, 1'b0, 32'h52, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 2, -1, 32'h0);
        add(1'b0, 2'b01, 1'b1, 32'h52, 32'h0000_0000, 32'h0000_00FF, 1'b0, 2, -1, 32'h0);
        add(1'b0, 2'b10, 1'b0, 32'h52, 32'h0000_0000, 32'hFFFF_80FF, 1'b0, 2, -1, 32'h0);
        add(1'b0, 2'b10, 1'b1, 32'h50, 32'h0000_0000, 32'h0000_7F01, 1'b0, 2, -1, 32'h0);
        add(1'b0, 2'b01, 1'b0, 32'h53, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 2, -1, 32'h0);
        add(1'b0, 2'b01, 1'b0, 32'h51, 32'h0000_0000, 32'h0000_007F, 1'b0, 2, -1, 32'h0);
        add(1'b0, 2'b11, 1'b0, 32'h50, 32'h0000_0000, 32'h0000_0001, 1'b0, 2, -1, 32'h0);
        add(1'b0, 2'b10, 1'b1, 32'h52, 32'h0000_0000, 32'h0000_80FF, 1'b0, 2, -1, 32'h0);
        add(1'b0, 2'b00, 1'b0, 32'h53, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, -1, 32'h0);
        add(1'b0, 2'b10, 1'b0, 32'h31, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, -1, 32'h0);
        add(1'b1, 2'b00, 1'b0, 32'h32, 32'h1234_5678, 32'h0000_0000, 1'b1, 1, -1, 32'h0);
        add(1'b1, 2'b10, 1'b0, 32'h33, 32'h0000_BEEF, 32'h0000_0000, 1'b1, 1, -1, 32'h0);
        add(1'b1, 2'b10, 1'b0, 32'h40, 32'hABCD_5555, 32'h0000_0000, 1'b0, 2, 1, 32'hFFFF_5555);
        add(1'b0, 2'b00, 1'b0, 32'h40, 32'h0000_0000, 32'hFFFF_5555, 1'b0, 2, -1, 32'h0);
        add(1'b1, 2'b01, 1'b0, 32'h33, 32'h0000_005A, 32'h0000_0000, 1'b0, 2, 1, 32'h5AFE_F00D);
        add(1'b0, 2'b00, 1'b0, 32'h30, 32'h0000_0000, 32'h5AFE_F00D, 1'b0, 2, -1, 32'h0);
        add(1'b1, 2'b10, 1'b0, 32'h42, 32'h0000_AAAA, 32'h0000_0000, 1'b0, 2, 1, 32'hAAAA_5555);
        add(1'b0, 2'b10, 1'b0, 32'h42, 32'h0000_0000, 32'hFFFF_AAAA, 1'b0, 2, -1, 32'h0);

        // Issued back-to-back: each request is raised the cycle after the previous ack
        for (int i = 0; i < vq.size(); i++) begin
            do_op(vq[i], i);
        end
        check("ram word 0x40", ram[16], 32'hAAAA_5555);

        // Reset while in ST_MERGE must suppress the pending write
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; ex_type = 2'b01; uns = 1'b0; addr = 32'h61; wdata = 32'h0000_0099;
        @(negedge clk);
        check("rst_mid stall cycle0", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        check("rst_mid in merge", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid mem_we forced", {31'd0, mem_we}, 32'd0);
        req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("rst_mid mem_we hold%0d", k), {31'd0, mem_we}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid ack", {31'd0, ack}, 32'd0);
        check("rst_mid rdata", rdata, 32'd0);
        check("rst_mid ram unchanged", ram[24], 32'h0102_0304);
        rv.we = 1'b0; rv.et = 2'b00; rv.uns = 1'b0; rv.addr = 32'h60; rv.wdata = 32'd0;
        rv.exp_rdata = 32'h0102_0304; rv.exp_err = 1'b0; rv.exp_lat = 2; rv.exp_wecyc = -1;
        rv.exp_wword = 32'd0;
        do_op(rv, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
